// File: rtl/equation_sequencer_if.sv
// Handshake/data bundle between the equation source (master) and the sequencer (slave).
interface equation_sequencer_if;
  logic       Start;
  logic       SecTick;
  logic       Go;
  logic [6:0] DataIn;
  logic [6:0] ExpAnswer;
  logic [1:0] EqIndex;
  logic       EqStart;
  logic       EqActive;
  logic [6:0] Timer;
  logic       Correct;
  logic       Wrong;
  logic [3:0] WrongCount;
  logic       NeedSequencer;
  logic       Done;
  logic [6:0] Score;

  modport master (
    output Start, SecTick, Go, DataIn, ExpAnswer,
    input  EqIndex, EqStart, EqActive, Timer, Correct, Wrong,
           WrongCount, NeedSequencer, Done, Score
  );

  modport slave (
    input  Start, SecTick, Go, DataIn, ExpAnswer,
    output EqIndex, EqStart, EqActive, Timer, Correct, Wrong,
           WrongCount, NeedSequencer, Done, Score
  );
endinterface

// File: rtl/equation_sequencer.sv
// Timed quiz sequencer: presents NUM_EQ equations, checks answers, counts misses.
// Optional macro EQ_SEQ_SCORE_EN adds a saturating correct-answer score register.
//
// state | meaning
// IDLE  | waiting for Start
// ASK   | present equation, load timer
// WAIT  | awaiting submit or timeout
// CHECK | compare latched answer
// NEXT  | advance equation or finish
// DONE  | session complete, results held
module equation_sequencer #(
  parameter int NUM_EQ     = 3,
  parameter int TIME_LIMIT = 20,
  parameter int MAX_TRIES  = 3
) (
  input logic                  Clock,
  input logic                  Reset,
  equation_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ASK, S_WAIT, S_CHECK, S_NEXT, S_DONE
  } state_t;

  localparam logic [6:0] TL   = 7'(TIME_LIMIT);
  localparam logic [3:0] MT   = 4'(MAX_TRIES);
  localparam logic [1:0] LAST = 2'(NUM_EQ - 1);

  state_t     state, state_nx;
  logic       go_q, go_rise, match, timeout, last_try;
  logic [6:0] answer, timer;
  logic [1:0] eq_index;
  logic [3:0] tries, wrong_count;
  logic       correct, wrong;
  logic       eq_start, eq_active, done, need_seq;

  assign go_rise  = bus.Go & ~go_q;
  assign match    = (answer == bus.ExpAnswer);
  // go_rise wins over a coincident final SecTick
  assign timeout  = (state == S_WAIT) && !go_rise && bus.SecTick && (timer == 7'd1);
  assign last_try = ((tries + 4'd1) == MT);

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.Start) state_nx = S_ASK;
      S_ASK:   state_nx = S_WAIT;
      S_WAIT:  if (go_rise) state_nx = S_CHECK;
               else if (timeout) state_nx = S_NEXT;
      S_CHECK: state_nx = (match || last_try) ? S_NEXT : S_WAIT;
      S_NEXT:  state_nx = (eq_index == LAST) ? S_DONE : S_ASK;
      S_DONE:  if (!bus.Start) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    eq_start  = (state == S_ASK);
    eq_active = (state == S_WAIT);
    done      = (state == S_DONE);
    need_seq  = (state == S_DONE) && (wrong_count != 4'd0);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      go_q        <= 1'b0;
      answer      <= '0;
      timer       <= '0;
      eq_index    <= '0;
      tries       <= '0;
      wrong_count <= '0;
      correct     <= 1'b0;
      wrong       <= 1'b0;
    end else begin
      go_q    <= bus.Go;
      correct <= 1'b0;
      wrong   <= 1'b0;
      case (state)
        S_IDLE: if (bus.Start) begin
          eq_index    <= '0;
          wrong_count <= '0;
        end
        S_ASK: begin
          timer <= TL;
          tries <= '0;
        end
        S_WAIT: begin
          if (go_rise) begin
            answer <= bus.DataIn;
          end else if (bus.SecTick && timer != 7'd0) begin
            timer <= timer - 7'd1;
          end
          if (timeout) begin
            wrong <= 1'b1;
            if (wrong_count != 4'hF) wrong_count <= wrong_count + 4'd1;
          end
        end
        S_CHECK: begin
          if (match) begin
            correct <= 1'b1;
          end else begin
            wrong <= 1'b1;
            tries <= tries + 4'd1;
            if (wrong_count != 4'hF) wrong_count <= wrong_count + 4'd1;
          end
        end
        S_NEXT: if (eq_index != LAST) eq_index <= eq_index + 2'd1;
        default: ;
      endcase
    end
  end

`ifdef EQ_SEQ_SCORE_EN
  logic [6:0] score;
  always_ff @(posedge Clock) begin
    if (Reset)
      score <= '0;
    else if (state == S_IDLE && bus.Start)
      score <= '0;
    else if (state == S_CHECK && match && score != 7'h7F)
      score <= score + 7'd1;
  end
  assign bus.Score = score;
`else
  assign bus.Score = '0;
`endif

  assign bus.EqIndex       = eq_index;
  assign bus.EqStart       = eq_start;
  assign bus.EqActive      = eq_active;
  assign bus.Timer         = timer;
  assign bus.Correct       = correct;
  assign bus.Wrong         = wrong;
  assign bus.WrongCount    = wrong_count;
  assign bus.NeedSequencer = need_seq;
  assign bus.Done          = done;

endmodule

// File: tb/tb_equation_sequencer.sv
// Directed scenarios plus randomized traffic, checked every cycle against a behavioural model.
module tb_equation_sequencer;
  localparam int NE = 3;
  localparam int TL = 20;
  localparam int MT = 3;

  logic Clock = 1'b0;
  logic Reset;
  equation_sequencer_if bus();

  equation_sequencer #(.NUM_EQ(NE), .TIME_LIMIT(TL), .MAX_TRIES(MT)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;
  int n_correct = 0;
  int n_wrong = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference, phrased directly in terms of session phases
  typedef enum {P_IDLE, P_ASK, P_WAIT, P_CHECK, P_NEXT, P_DONE} phase_t;
  phase_t m_ph = P_IDLE;
  int m_timer = 0, m_idx = 0, m_wc = 0, m_score = 0, m_tries = 0, m_ans = 0;
  bit m_go_prev = 0, m_correct = 0, m_wrong = 0;

  task automatic model_step();
    bit rise;
    if (Reset) begin
      m_ph = P_IDLE; m_timer = 0; m_idx = 0; m_wc = 0; m_score = 0;
      m_tries = 0; m_go_prev = 0; m_correct = 0; m_wrong = 0;
      return;
    end
    rise = bus.Go && !m_go_prev;
    m_go_prev = bus.Go;
    m_correct = 0;
    m_wrong = 0;
    case (m_ph)
      P_IDLE: if (bus.Start) begin m_idx = 0; m_wc = 0; m_score = 0; m_ph = P_ASK; end
      P_ASK: begin m_timer = TL; m_tries = 0; m_ph = P_WAIT; end
      P_WAIT:
        if (rise) begin
          m_ans = bus.DataIn; m_ph = P_CHECK;
        end else if (bus.SecTick && m_timer == 1) begin
          m_timer = 0; m_wrong = 1; m_wc = (m_wc < 15) ? m_wc + 1 : 15; m_ph = P_NEXT;
        end else if (bus.SecTick && m_timer > 0) begin
          m_timer--;
        end
      P_CHECK:
        if (m_ans == int'(bus.ExpAnswer)) begin
          m_correct = 1;
`ifdef EQ_SEQ_SCORE_EN
          m_score = (m_score < 127) ? m_score + 1 : 127;
`endif
          m_ph = P_NEXT;
        end else begin
          m_wrong = 1; m_wc = (m_wc < 15) ? m_wc + 1 : 15; m_tries++;
          m_ph = (m_tries == MT) ? P_NEXT : P_WAIT;
        end
      P_NEXT:
        if (m_idx == NE - 1) m_ph = P_DONE;
        else begin m_idx++; m_ph = P_ASK; end
      P_DONE: if (!bus.Start) m_ph = P_IDLE;
      default: m_ph = P_IDLE;
    endcase
  endtask

  always @(posedge Clock) model_step();

  always @(negedge Clock) begin
    chk("EqIndex", bus.EqIndex, m_idx);
    chk("EqStart", bus.EqStart, m_ph == P_ASK);
    chk("EqActive", bus.EqActive, m_ph == P_WAIT);
    chk("Timer", bus.Timer, m_timer);
    chk("Correct", bus.Correct, m_correct);
    chk("Wrong", bus.Wrong, m_wrong);
    chk("WrongCount", bus.WrongCount, m_wc);
    chk("NeedSequencer", bus.NeedSequencer, (m_ph == P_DONE) && (m_wc != 0));
    chk("Done", bus.Done, m_ph == P_DONE);
    chk("Score", bus.Score, m_score);
    if (bus.Correct === 1'b1) n_correct++;
    if (bus.Wrong === 1'b1) n_wrong++;
  end

  task automatic step();
    @(negedge Clock);
    #1;
  endtask

  task automatic wait_active();
    for (int i = 0; i < 100 && bus.EqActive !== 1'b1; i++) step();
    chk("wait_active", bus.EqActive, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && bus.Done !== 1'b1; i++) step();
    chk("wait_done", bus.Done, 1);
  endtask

  task automatic press(input logic [6:0] v);
    bus.DataIn = v; bus.Go = 1'b1; step();
    bus.Go = 1'b0; step();
  endtask

  task automatic tick();
    bus.SecTick = 1'b1; step();
    bus.SecTick = 1'b0;
  endtask

  logic [6:0] exp_tab [NE];
  int c0, w0;

  initial begin
    Reset = 1'b1;
    bus.Start = 0; bus.SecTick = 0; bus.Go = 0; bus.DataIn = 0; bus.ExpAnswer = 0;
    repeat (3) step();
    Reset = 1'b0;
    step();
    chk("rst_timer", bus.Timer, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_eqindex", bus.EqIndex, 0);

    // All three answered correctly
    c0 = n_correct;
    bus.Start = 1; bus.ExpAnswer = 12;
    for (int e = 0; e < NE; e++) begin
      wait_active();
      chk("all_ok_index", bus.EqIndex, e);
      press(12);
    end
    wait_done();
    chk("all_ok_ncorrect", n_correct - c0, 3);
    chk("all_ok_needseq", bus.NeedSequencer, 0);
    chk("all_ok_lastidx", bus.EqIndex, 2);
`ifdef EQ_SEQ_SCORE_EN
    chk("all_ok_score", bus.Score, 3);
`else
    chk("all_ok_score", bus.Score, 0);
`endif

    // DONE holds while Start stays high, restarts after a low
    repeat (5) step();
    chk("done_hold", bus.Done, 1);
    bus.Start = 0; step();
    chk("done_exit", bus.Done, 0);
    bus.Start = 1; bus.ExpAnswer = 7; step();
    chk("restart_eqstart", bus.EqStart, 1);
    chk("restart_wc", bus.WrongCount, 0);

    // Three wrong tries force advance, timer not reloaded between tries
    w0 = n_wrong;
    wait_active();
    chk("tries_timer_init", bus.Timer, TL);
    press(5);
    tick();
    press(5);
    chk("tries_timer_kept", bus.Timer, TL - 1);
    press(5);
    chk("tries_nwrong", n_wrong - w0, 3);
    wait_active();
    chk("tries_index", bus.EqIndex, 1);
    chk("tries_wc", bus.WrongCount, 3);

    // Mid-session reset
    Reset = 1; step();
    Reset = 0;
    chk("rst_mid_idx", bus.EqIndex, 0);
    chk("rst_mid_wc", bus.WrongCount, 0);
    chk("rst_mid_timer", bus.Timer, 0);
    chk("rst_mid_active", bus.EqActive, 0);
    wait_active();
    chk("rst_new_session", bus.EqIndex, 0);

    // Timeout: full countdown without a submit
    w0 = n_wrong;
    for (int k = 1; k <= TL; k++) begin
      tick();
      chk("countdown", bus.Timer, TL - k);
    end
    chk("timeout_nwrong", n_wrong - w0, 1);
    wait_active();
    chk("timeout_index", bus.EqIndex, 1);
    chk("timeout_reload", bus.Timer, TL);

    // Submit coincident with final tick wins
    for (int k = 1; k < TL; k++) tick();
    chk("race_timer", bus.Timer, 1);
    c0 = n_correct; w0 = n_wrong;
    bus.ExpAnswer = 9; bus.DataIn = 9; bus.Go = 1; bus.SecTick = 1; step();
    bus.Go = 0; bus.SecTick = 0; step();
    chk("race_correct", n_correct - c0, 1);
    chk("race_nowrong", n_wrong - w0, 0);

    // Randomized traffic
    for (int i = 0; i < NE; i++) exp_tab[i] = 7'($urandom_range(0, 127));
    for (int i = 0; i < 4000; i++) begin
      Reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 9) == 0) bus.Start = ~bus.Start;
      bus.SecTick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) bus.Go = ~bus.Go;
      bus.ExpAnswer = exp_tab[m_idx];
      bus.DataIn = $urandom_range(0, 1) ? exp_tab[m_idx] : 7'($urandom_range(0, 127));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
